// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic mst_idx_t;

    localparam logic [2:0] CTI_EOB = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// Wishbone bus bundle shared by the masters and the SDRAM slave port.
interface wshb_if #(
    parameter int unsigned DATA_BYTES = 4
) ();

    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;
    logic [8*DATA_BYTES-1:0] dat_sm;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty, dat_sm
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty, dat_sm
    );

endinterface

// File: rtl/wshb_rr_pick.sv
// Round-robin winner selection between two requesters.
module wshb_rr_pick
    import sdram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  mst_idx_t   rr_ptr,
    output mst_idx_t   win
);

    // Pointer breaks ties; a lone requester always wins.
    always_comb begin
        win = mst_idx_t'(1'b0);
        if (&req) begin
            win = rr_ptr;
        end else if (req[1]) begin
            win = mst_idx_t'(1'b1);
        end
    end

endmodule

// File: rtl/sdram_wshb_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM Wishbone slave.
// Optional per-master ack statistics: define SDRAM_ARB_STATS_EN.
module sdram_wshb_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned MAX_GNT    = 64
) (
    input  logic   sys_clk,
    input  logic   sys_rst,
    wshb_if.slave  wshb_ifs_0,
    wshb_if.slave  wshb_ifs_1,
    wshb_if.master wshb_ifm
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [15:0] gnt_cnt_0,
    output logic [15:0] gnt_cnt_1
`endif
);

    localparam int unsigned DAT_W  = 8 * DATA_BYTES;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNT_W1 = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   MAX_GNT_V = CNT_W1'(MAX_GNT);

    arb_state_t       state, state_nxt;
    mst_idx_t         rr_ptr, rr_ptr_nxt, pick;
    logic [CNT_W-1:0] ack_cnt, ack_cnt_nxt;
    logic [1:0]       req;
    logic             gnt_act, gnt_sel;
    logic             cyc_x, cyc_y, stb_x;
    logic [2:0]       cti_x;
    logic             ack_seen, term, eob, quota;
    logic             ack_0_c, ack_1_c;

    assign req = {wshb_ifs_1.cyc, wshb_ifs_0.cyc};

    wshb_rr_pick u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .win    (pick)
    );

    // Granted-master view used by the tenure logic.
    always_comb begin
        gnt_act  = (state != IDLE) && !sys_rst;
        gnt_sel  = (state == GNT1);
        cyc_x    = gnt_sel ? wshb_ifs_1.cyc : wshb_ifs_0.cyc;
        cyc_y    = gnt_sel ? wshb_ifs_0.cyc : wshb_ifs_1.cyc;
        stb_x    = gnt_sel ? wshb_ifs_1.stb : wshb_ifs_0.stb;
        cti_x    = gnt_sel ? wshb_ifs_1.cti : wshb_ifs_0.cti;
        ack_seen = wshb_ifm.ack && stb_x;
        term     = !cyc_x || ((wshb_ifm.err || wshb_ifm.rty) && stb_x);
        eob      = (cti_x == CTI_EOB);
        quota    = (MAX_GNT != 0) && (({1'b0, ack_cnt} + CNT_W1'(1)) >= MAX_GNT_V);
        ack_0_c  = gnt_act && !gnt_sel && wshb_ifm.ack;
        ack_1_c  = gnt_act &&  gnt_sel && wshb_ifm.ack;
    end

    // Forward path: granted master drives the SDRAM port, idle bus otherwise.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = DAT_W'(0);
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        if (gnt_act && !gnt_sel) begin
            wshb_ifm.cyc    = wshb_ifs_0.cyc;
            wshb_ifm.stb    = wshb_ifs_0.stb;
            wshb_ifm.we     = wshb_ifs_0.we;
            wshb_ifm.adr    = wshb_ifs_0.adr;
            wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
            wshb_ifm.sel    = wshb_ifs_0.sel;
            wshb_ifm.cti    = wshb_ifs_0.cti;
            wshb_ifm.bte    = wshb_ifs_0.bte;
        end else if (gnt_act && gnt_sel) begin
            wshb_ifm.cyc    = wshb_ifs_1.cyc;
            wshb_ifm.stb    = wshb_ifs_1.stb;
            wshb_ifm.we     = wshb_ifs_1.we;
            wshb_ifm.adr    = wshb_ifs_1.adr;
            wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
            wshb_ifm.sel    = wshb_ifs_1.sel;
            wshb_ifm.cti    = wshb_ifs_1.cti;
            wshb_ifm.bte    = wshb_ifs_1.bte;
        end
    end

    // Return path: only the granted master sees responses; the other stalls.
    always_comb begin
        wshb_ifs_0.ack    = ack_0_c;
        wshb_ifs_0.err    = gnt_act && !gnt_sel && wshb_ifm.err;
        wshb_ifs_0.rty    = gnt_act && !gnt_sel && wshb_ifm.rty;
        wshb_ifs_0.dat_sm = (gnt_act && !gnt_sel) ? wshb_ifm.dat_sm : DAT_W'(0);
        wshb_ifs_1.ack    = ack_1_c;
        wshb_ifs_1.err    = gnt_act && gnt_sel && wshb_ifm.err;
        wshb_ifs_1.rty    = gnt_act && gnt_sel && wshb_ifm.rty;
        wshb_ifs_1.dat_sm = (gnt_act && gnt_sel) ? wshb_ifm.dat_sm : DAT_W'(0);
    end

    // Next grant, pointer and tenure ack count.
    always_comb begin
        state_nxt   = state;
        rr_ptr_nxt  = rr_ptr;
        ack_cnt_nxt = ack_cnt;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = pick ? GNT1 : GNT0;
                    if (&req) begin
                        rr_ptr_nxt = mst_idx_t'(~pick);
                    end
                end
            end
            GNT0, GNT1: begin
                if (term) begin
                    state_nxt = cyc_y ? (gnt_sel ? GNT0 : GNT1) : IDLE;
                end else if (ack_seen && cyc_y && (eob || quota)) begin
                    state_nxt = gnt_sel ? GNT0 : GNT1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) begin
            ack_cnt_nxt = '0;
        end else if (ack_seen && (state != IDLE) && (ack_cnt != CNT_MAX)) begin
            ack_cnt_nxt = ack_cnt + CNT_W'(1);
        end
    end

    // State, pointer and counter registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= IDLE;
            rr_ptr  <= mst_idx_t'(1'b0);
            ack_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rr_ptr  <= rr_ptr_nxt;
            ack_cnt <= ack_cnt_nxt;
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    // Saturating per-master delivered-ack counters.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gnt_cnt_0 <= '0;
            gnt_cnt_1 <= '0;
        end else begin
            if (ack_0_c && (gnt_cnt_0 != 16'hFFFF)) gnt_cnt_0 <= gnt_cnt_0 + 16'd1;
            if (ack_1_c && (gnt_cnt_1 != 16'hFFFF)) gnt_cnt_1 <= gnt_cnt_1 + 16'd1;
        end
    end
`endif

endmodule
